y_dequantizer: RTL and testbench

Inverse of the luma quantization stage: accepts an 8x8 block of 11-bit signed quantized Y coefficients and multiplies each by the matching entry of the standard JPEG luminance quantization table. It produces an 8x8 block of reconstructed DCT coefficients. It sits in the decode/loop-back path between entropy decode and the inverse DCT. It also serves as a round-trip checker for the luma quantizer. Rows are processed one per cycle with eight parallel multipliers, sequenced by a small FSM.

---
 rtl/jpeg_quant_pkg.sv | 23 ++
 rtl/dequant_row.sv | 34 +++
 rtl/y_dequantizer.sv | 78 +++++++
 tb/tb_y_dequantizer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_quant_pkg.sv
// Shared JPEG luma quantization constants and types, used by both the forward
// quantizer and y_dequantizer.
package jpeg_quant_pkg;

   typedef logic signed [10:0] coef_t;
   typedef logic [7:0]         qentry_t;

   localparam int COEF_MAX = 1023;
   localparam int COEF_MIN = -1024;

   // Standard JPEG luminance table, row-major.
   localparam qentry_t Y_QUANT_TABLE [0:7][0:7] = '{
      '{8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61},
      '{8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55},
      '{8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56},
      '{8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62},
      '{8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77},
      '{8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92},
      '{8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101},
      '{8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99}
   };

endpackage

// File: rtl/dequant_row.sv
// Combinational row dequantizer: eight exact products reduced to 11 bits.
// DEQUANT_SAT_EN selects saturation; otherwise products wrap to their low 11 bits.
module dequant_row
   import jpeg_quant_pkg::*;
(
   input  coef_t   q [0:7],
   input  qentry_t t [0:7],
   output coef_t   z [0:7]
);

   localparam logic signed [18:0] PROD_MAX = 19'(COEF_MAX);
   localparam logic signed [18:0] PROD_MIN = 19'(COEF_MIN);

   logic signed [18:0] prod [0:7];

   // NOTE: both operands are widened to 19 bits before multiplying; an 11x9
   // multiply in a self-determined context would otherwise be cut to 11 bits.
   always_comb begin
      for (int c = 0; c < 8; c++) begin
         prod[c] = $signed({{8{q[c][10]}}, q[c]}) * $signed({11'b0, t[c]});
`ifdef DEQUANT_SAT_EN
         if (prod[c] > PROD_MAX)
            z[c] = coef_t'(COEF_MAX);
         else if (prod[c] < PROD_MIN)
            z[c] = coef_t'(COEF_MIN);
         else
            z[c] = prod[c][10:0];
`else
         z[c] = prod[c][10:0];
`endif
      end
   end

endmodule

// File: rtl/y_dequantizer.sv
// 8x8 luma dequantizer: latches a block, then rebuilds one Z row per cycle.
// Optional saturation is selected by DEQUANT_SAT_EN inside dequant_row.
module y_dequantizer
   import jpeg_quant_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  enable,
   input  coef_t Q [0:7][0:7],
   output coef_t Z [0:7][0:7],
   output logic  out_enable,
   output logic  busy
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t     state;
   logic [2:0] row;
   coef_t      blk [0:7][0:7];

   coef_t   row_q [0:7];
   qentry_t row_t [0:7];
   coef_t   row_z [0:7];

   always_comb begin
      for (int c = 0; c < 8; c++) begin
         row_q[c] = blk[row][c];
         row_t[c] = Y_QUANT_TABLE[row][c];
      end
   end

   dequant_row u_row (
      .q (row_q),
      .t (row_t),
      .z (row_z)
   );

   // NOTE: the block and Z registers are reset too, because the reset state
   // of Z is observable and an aborted block must leave nothing behind.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         row        <= '0;
         busy       <= 1'b0;
         out_enable <= 1'b0;
         for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
               blk[r][c] <= '0;
               Z[r][c]   <= '0;
            end
         end
      end else begin
         out_enable <= 1'b0;
         case (state)
            IDLE: begin
               if (enable) begin
                  blk   <= Q;
                  row   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               for (int c = 0; c < 8; c++)
                  Z[row][c] <= row_z[c];
               row <= row + 3'd1;
               if (row == 3'd7) begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  out_enable <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_y_dequantizer.sv
// Directed bench for y_dequantizer with a queue of expected blocks popped on
// each out_enable pulse. Expected values come from an integer reference model.
module tb_y_dequantizer;
   import jpeg_quant_pkg::*;

   typedef logic [0:63][10:0] blk_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   logic  enable = 1'b0;
   coef_t Q [0:7][0:7];
   coef_t Z [0:7][0:7];
   logic  out_enable;
   logic  busy;

   int    passed = 0;
   int    total  = 0;
   blk_t  sb [$];

   y_dequantizer dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .Q          (Q),
      .Z          (Z),
      .out_enable (out_enable),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   function automatic int ref_coef(input int q, input int t);
      int p;
      p = q * t;
`ifdef DEQUANT_SAT_EN
      if (p > 1023) return 1023;
      if (p < -1024) return -1024;
      return p;
`else
      p = (p + 1024) % 2048;
      if (p < 0) p += 2048;
      return p - 1024;
`endif
   endfunction

   // Expected block for whatever is currently on Q.
   function automatic blk_t ref_block();
      blk_t b;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            b[r*8+c] = 11'(ref_coef(int'(Q[r][c]), int'(Y_QUANT_TABLE[r][c])));
      return b;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_q(input int v);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            Q[r][c] = 11'(v);
   endtask

   task automatic scramble_q();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            Q[r][c] = 11'($urandom_range(0, 2047));
   endtask

   task automatic check_z_zero(input string tag);
      int bad = 0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            if (Z[r][c] !== 11'sd0) bad++;
      check(tag, bad, 0);
   endtask

   task automatic compare_block(input string tag);
      blk_t exp;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 1, 0);
         return;
      end
      exp = sb.pop_front();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            check($sformatf("%s_z%0d%0d", tag, r, c), int'(Z[r][c]), int'($signed(exp[r*8+c])));
   endtask

   // Accept the block on Q at the next edge, then leave enable low.
   task automatic accept();
      sb.push_back(ref_block());
      enable = 1'b1;
      tick();
      enable = 1'b0;
      check("busy_after_accept", int'(busy), 1);
   endtask

   // Wait (bounded) for out_enable; checks latency in cycles since the last tick.
   task automatic wait_out(input string tag, input int exp_lat);
      int n = 0;
      while (n < 20) begin
         tick();
         n++;
         if (out_enable === 1'b1) break;
      end
      check({tag, "_latency"}, n, exp_lat);
      check({tag, "_busy_at_out"}, int'(busy), 0);
      compare_block(tag);
   endtask

   initial begin
      int pulses;
      int first_at;
      int second_at;
      int seen;

      set_q(0);
      tick();
      tick();
      rst = 1'b0;
      check("reset_out_enable", int'(out_enable), 0);
      check("reset_busy", int'(busy), 0);
      check_z_zero("reset_z");

      // All ones: Z must reproduce the table.
      set_q(1);
      accept();
      scramble_q();
      wait_out("ones", 8);
      check("ones_z00", int'(Z[0][0]), 16);
      check("ones_z65", int'(Z[6][5]), 121);
      check("ones_z77", int'(Z[7][7]), 99);
      tick();
      check("pulse_width", int'(out_enable), 0);

      // Out-of-range products at both corners.
      set_q(0);
      Q[0][0] = 11'sd100;
      Q[7][7] = -11'sd11;
      accept();
      wait_out("corners", 8);
`ifdef DEQUANT_SAT_EN
      check("corners_z00", int'(Z[0][0]), 1023);
      check("corners_z77", int'(Z[7][7]), -1024);
`else
      check("corners_z00", int'(Z[0][0]), -448);
      check("corners_z77", int'(Z[7][7]), 959);
`endif

      // Negative in-range and top-of-range products; first back-to-back block.
      set_q(0);
      Q[3][2] = -11'sd5;
      Q[0][1] = 11'sd93;
      accept();
      scramble_q();
      wait_out("mixed", 8);
      check("mixed_z32", int'(Z[3][2]), -110);
      check("mixed_z01", int'(Z[0][1]), 1023);

      // enable during the out_enable cycle is taken at once: 9 cycles pulse-to-pulse.
      set_q(0);
      for (int c = 0; c < 8; c++) Q[c][c] = 11'(-3 - c * 40);
      accept();
      scramble_q();
      wait_out("b2b", 8);

      // Enable held high: exactly two pulses, nine cycles apart.
      set_q(2);
      sb.push_back(ref_block());
      sb.push_back(ref_block());
      enable = 1'b1;
      pulses = 0;
      first_at = -1;
      second_at = -1;
      for (int i = 0; i < 26; i++) begin
         tick();
         if (i == 17) enable = 1'b0;
         if (out_enable === 1'b1) begin
            pulses++;
            if (first_at < 0) first_at = i;
            else second_at = i;
            compare_block("held");
         end
      end
      check("held_pulses", pulses, 2);
      check("held_spacing", second_at - first_at, 9);
      check("held_sb_drained", sb.size(), 0);

      // Reset mid-block: everything clears and no pulse follows.
      set_q(1);
      enable = 1'b1;
      tick();
      enable = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_out_enable", int'(out_enable), 0);
      check_z_zero("abort_z");
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_enable === 1'b1) seen++;
      end
      check("abort_no_pulse", seen, 0);

      // Normal operation after the abort.
      set_q(-1);
      accept();
      wait_out("after_abort", 8);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
